// File: rtl/decrypt_key_sequencer_if.sv
// Key issue handshake between the decrypt key sequencer and the cipher round engine.
// The master side offers keys. The slave side (the round engine) accepts them with key_ready.
interface decrypt_key_sequencer_if #(
   parameter int unsigned KEY_WIDTH = 64,
   parameter int unsigned NUM_KEYS  = 3
);
   localparam int unsigned IDX_W = $clog2(NUM_KEYS);

   logic                 key_valid;
   logic                 key_ready;
   logic [KEY_WIDTH-1:0] key_data;
   logic [IDX_W-1:0]     key_index;
   logic                 key_last;

   modport master (
      output key_valid,
      output key_data,
      output key_index,
      output key_last,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_data,
      input  key_index,
      input  key_last,
      output key_ready
   );
endinterface

// File: rtl/decrypt_key_sequencer.sv
// Decrypt key sequencer: stores NUM_KEYS cipher keys and, on start, issues them
// to the round engine in reverse order (NUM_KEYS-1 down to 0) over valid/ready.
// The final key is flagged with key_last, and done pulses one cycle afterwards.
// Optional feature macro: KEY_SEQ_ZEROIZE_EN clears the key store in the DONE state.
module decrypt_key_sequencer #(
   parameter  int unsigned KEY_WIDTH = 64,
   parameter  int unsigned NUM_KEYS  = 3,
   localparam int unsigned IDX_W     = $clog2(NUM_KEYS)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 key_wr_en,
   input  logic [IDX_W-1:0]     key_wr_idx,
   input  logic [KEY_WIDTH-1:0] key_wr_data,
   input  logic                 start,
   decrypt_key_sequencer_if.master key_bus,
   output logic                 busy,
   output logic                 done,
   output logic                 wr_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [IDX_W-1:0]     index;
   logic [IDX_W-1:0]     index_nx;
   logic [KEY_WIDTH-1:0] store [NUM_KEYS];

   logic                 valid_c;
   logic                 done_c;
   logic                 wr_ok_c;
   logic                 idx_in_range_c;

   // Writes are accepted only while idle and only for existing slots.
   assign idx_in_range_c = 32'(key_wr_idx) < NUM_KEYS;
   assign wr_ok_c        = key_wr_en && (state == ST_IDLE) && idx_in_range_c;

   // State and index registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= ST_IDLE;
         index <= '0;
      end else begin
         state <= state_nx;
         index <= index_nx;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nx = state;
      index_nx = index;
      valid_c  = 1'b0;
      done_c   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = ST_ISSUE;
               index_nx = IDX_W'(NUM_KEYS - 1);
            end
         end
         ST_ISSUE: begin
            valid_c = 1'b1;
            if (key_bus.key_ready) begin
               if (index == '0) begin
                  state_nx = ST_DONE;
               end else begin
                  index_nx = index - IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            done_c   = 1'b1;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Key store: cleared on reset (and optionally in DONE), otherwise written while idle.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            store[i] <= '0;
         end
`ifdef KEY_SEQ_ZEROIZE_EN
      end else if (state == ST_DONE) begin
         for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            store[i] <= '0;
         end
`else
`endif
      end else if (wr_ok_c) begin
         store[key_wr_idx] <= key_wr_data;
      end
   end

   // Rejected-write flag, one cycle after the offending write.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= key_wr_en && !wr_ok_c;
      end
   end

   // The store is frozen while busy, so a direct read stays stable across stalls.
   assign key_bus.key_valid = valid_c;
   assign key_bus.key_index = index;
   assign key_bus.key_data  = store[index];
   assign key_bus.key_last  = valid_c && (index == '0);
   assign busy              = (state != ST_IDLE);
   assign done              = done_c;

endmodule
